// File: rtl/mem_stage.sv
// mem_stage: LoongArch MEM stage between EX and WB.
// Holds one instruction from EX, waits for the data-SRAM response of loads and
// stores, aligns/extends load data and hands the result to WB. Bypass and hazard
// information goes back to ID, exception/ertn status back to EX.
//
// Handshake: a transfer EX->MEM happens on a rising edge where ex_to_mem_valid and
// mem_allowin are both high; MEM->WB happens where mem_to_wb_valid and wb_allowin
// are both high. A valid is never qualified by its own ready.
//
// Every SRAM request accepted in EX owes exactly one data_ok, and responses come
// back in order. outst_cnt counts responses still owed. On a flush, every owed
// response belongs to a killed instruction, so discard_cnt is loaded with that
// number and the matching data_ok pulses are swallowed without effect.
module mem_stage #(
   parameter int MAX_OUTST = 2,
   localparam int CW = $clog2(MAX_OUTST + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,

   input  logic          ex_to_mem_valid,
   output logic          mem_allowin,
   input  logic [31:0]   ex_pc,
   input  logic [31:0]   ex_result,
   input  logic          ex_rf_we,
   input  logic [4:0]    ex_rf_waddr,
   input  logic          ex_res_from_mem,
   input  logic [2:0]    ex_ld_op,
   input  logic [1:0]    ex_addr_lo,
   input  logic          ex_mem_req,
   input  logic          ex_excep_en,
   input  logic          ex_ertn,

   input  logic          req_accepted,
   input  logic          data_sram_data_ok,
   input  logic [31:0]   data_sram_rdata,

   input  logic          wb_allowin,
   output logic          mem_to_wb_valid,
   output logic [31:0]   mem_pc,
   output logic [31:0]   mem_final_result,
   output logic          mem_rf_we,
   output logic [4:0]    mem_rf_waddr,
   output logic          mem_excep_en,
   output logic [1:0]    mem_to_ex_bus,
   output logic [38:0]   mem_to_id_bus,

   output logic [CW-1:0] dbg_outst_cnt,
   output logic [CW-1:0] dbg_discard_cnt,
   output logic          dbg_rbuf_valid
);

   // ------------------------------------------------------------------
   // Stage state
   // ------------------------------------------------------------------
   logic          mem_valid;
   logic [31:0]   pc_q;
   logic [31:0]   result_q;
   logic          rf_we_q;
   logic [4:0]    rf_waddr_q;
   logic          res_from_mem_q;
   logic [2:0]    ld_op_q;
   logic [1:0]    addr_lo_q;
   logic          mem_req_q;
   logic          excep_en_q;
   logic          ertn_q;

   logic [CW-1:0] outst_cnt;
   logic [CW-1:0] outst_next;
   logic [CW-1:0] discard_cnt;
   logic          discard_idle;

   logic          rbuf_valid;
   logic [31:0]   rbuf;

   logic          data_ok_eff;
   logic          ready_go;
   logic          leave;
   logic          load_pending;

   logic [31:0]   rdata_src;
   logic [31:0]   shifted;
   logic [31:0]   load_data;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   assign discard_idle    = (discard_cnt == '0);
   // A response is ours only when no killed instruction is still owed one.
   assign data_ok_eff     = data_sram_data_ok & discard_idle;
   assign ready_go        = ~mem_req_q | data_ok_eff | rbuf_valid;
   assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid & ready_go & ~flush;
   assign leave           = mem_valid & ready_go & wb_allowin;

   // Stage valid: flush kills the occupant, otherwise refill whenever allowed.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_valid <= 1'b0;
      end else if (flush) begin
         mem_valid <= 1'b0;
      end else if (mem_allowin) begin
         mem_valid <= ex_to_mem_valid;
      end
   end

   // Latch the EX payload on each EX->MEM transfer.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_q           <= 32'h0;
         result_q       <= 32'h0;
         rf_we_q        <= 1'b0;
         rf_waddr_q     <= 5'h0;
         res_from_mem_q <= 1'b0;
         ld_op_q        <= 3'h0;
         addr_lo_q      <= 2'h0;
         mem_req_q      <= 1'b0;
         excep_en_q     <= 1'b0;
         ertn_q         <= 1'b0;
      end else if (ex_to_mem_valid & mem_allowin) begin
         pc_q           <= ex_pc;
         result_q       <= ex_result;
         rf_we_q        <= ex_rf_we;
         rf_waddr_q     <= ex_rf_waddr;
         res_from_mem_q <= ex_res_from_mem;
         ld_op_q        <= ex_ld_op;
         addr_lo_q      <= ex_addr_lo;
         mem_req_q      <= ex_mem_req;
         excep_en_q     <= ex_excep_en;
         ertn_q         <= ex_ertn;
      end
   end

   // ------------------------------------------------------------------
   // Response buffer: the SRAM presents rdata for one cycle only, so a
   // response that arrives while WB is stalled is kept here until the
   // instruction moves on.
   // ------------------------------------------------------------------
   // Capture a live response when WB cannot take it; drop on leave or flush.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rbuf_valid <= 1'b0;
         rbuf       <= 32'h0;
      end else if (flush | leave) begin
         rbuf_valid <= 1'b0;
      end else if (data_ok_eff & mem_valid & ~wb_allowin) begin
         rbuf_valid <= 1'b1;
         rbuf       <= data_sram_rdata;
      end
   end

   // ------------------------------------------------------------------
   // Outstanding / discard bookkeeping
   // ------------------------------------------------------------------
   // Accept and response in the same cycle cancel; the caller keeps the
   // true count within 0..MAX_OUTST, so modular arithmetic is exact.
   assign outst_next = outst_cnt + CW'(req_accepted) - CW'(data_sram_data_ok);

   // Count responses still owed by the SRAM.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         outst_cnt <= '0;
      end else begin
         outst_cnt <= outst_next;
      end
   end

   // On flush, everything still owed after this cycle belongs to killed
   // instructions; swallow that many responses afterwards.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         discard_cnt <= '0;
      end else if (flush) begin
         discard_cnt <= outst_next;
      end else if (data_sram_data_ok & ~discard_idle) begin
         discard_cnt <= discard_cnt - CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Load alignment and result select
   // ------------------------------------------------------------------
   assign rdata_src = rbuf_valid ? rbuf : data_sram_rdata;
   assign shifted   = rdata_src >> {addr_lo_q, 3'b000};

   // Extract byte/half/word; ld_op is {b, h, u}.
   always_comb begin
      load_data = rdata_src;
      if (ld_op_q[2]) begin
         load_data = {{24{~ld_op_q[0] & shifted[7]}}, shifted[7:0]};
      end else if (ld_op_q[1]) begin
         load_data = {{16{~ld_op_q[0] & shifted[15]}}, shifted[15:0]};
      end
   end

   // A faulting load carries no request and forwards its bad address.
   assign mem_final_result = (res_from_mem_q & ~excep_en_q) ? load_data : result_q;

   // ID must stall on a consumer while the load value is not yet known.
   assign load_pending = mem_valid & res_from_mem_q & ~ready_go;

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_pc        = pc_q;
   assign mem_rf_we     = rf_we_q & mem_valid;
   assign mem_rf_waddr  = rf_waddr_q;
   assign mem_excep_en  = excep_en_q & mem_valid;
   assign mem_to_ex_bus = {excep_en_q & mem_valid, ertn_q & mem_valid};
   assign mem_to_id_bus = {load_pending, rf_we_q & mem_valid, rf_waddr_q, mem_final_result};

   assign dbg_outst_cnt   = outst_cnt;
   assign dbg_discard_cnt = discard_cnt;
   assign dbg_rbuf_valid  = rbuf_valid;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: bench for mem_stage.
// The bench plays EX and the data SRAM. A transaction-level model tracks the
// instruction held in MEM, whether its data has arrived, and the list of
// responses the SRAM still owes (each tagged live or killed by a flush).
module tb_mem_stage;
   localparam int MAX_OUTST = 2;
   localparam int CW = $clog2(MAX_OUTST + 1);

   logic          clk;
   logic          resetn;
   logic          flush;
   logic          ex_to_mem_valid;
   logic          mem_allowin;
   logic [31:0]   ex_pc;
   logic [31:0]   ex_result;
   logic          ex_rf_we;
   logic [4:0]    ex_rf_waddr;
   logic          ex_res_from_mem;
   logic [2:0]    ex_ld_op;
   logic [1:0]    ex_addr_lo;
   logic          ex_mem_req;
   logic          ex_excep_en;
   logic          ex_ertn;
   logic          req_accepted;
   logic          data_sram_data_ok;
   logic [31:0]   data_sram_rdata;
   logic          wb_allowin;
   logic          mem_to_wb_valid;
   logic [31:0]   mem_pc;
   logic [31:0]   mem_final_result;
   logic          mem_rf_we;
   logic [4:0]    mem_rf_waddr;
   logic          mem_excep_en;
   logic [1:0]    mem_to_ex_bus;
   logic [38:0]   mem_to_id_bus;
   logic [CW-1:0] dbg_outst_cnt;
   logic [CW-1:0] dbg_discard_cnt;
   logic          dbg_rbuf_valid;

   mem_stage #(.MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
      .ex_pc(ex_pc), .ex_result(ex_result), .ex_rf_we(ex_rf_we),
      .ex_rf_waddr(ex_rf_waddr), .ex_res_from_mem(ex_res_from_mem),
      .ex_ld_op(ex_ld_op), .ex_addr_lo(ex_addr_lo), .ex_mem_req(ex_mem_req),
      .ex_excep_en(ex_excep_en), .ex_ertn(ex_ertn),
      .req_accepted(req_accepted), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata), .wb_allowin(wb_allowin),
      .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc),
      .mem_final_result(mem_final_result), .mem_rf_we(mem_rf_we),
      .mem_rf_waddr(mem_rf_waddr), .mem_excep_en(mem_excep_en),
      .mem_to_ex_bus(mem_to_ex_bus), .mem_to_id_bus(mem_to_id_bus),
      .dbg_outst_cnt(dbg_outst_cnt), .dbg_discard_cnt(dbg_discard_cnt),
      .dbg_rbuf_valid(dbg_rbuf_valid)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] result;
      logic        rf_we;
      logic [4:0]  waddr;
      logic        res_from_mem;
      logic [2:0]  ld_op;
      logic [1:0]  addr_lo;
      logic        mem_req;
      logic        excep;
      logic        ertn;
   } instr_t;

   typedef struct {
      logic [31:0] data;
      int          due;
      bit          dead;
   } resp_t;

   // ---------------- clock/reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   // ---------------- bench state ----------------
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   resp_t       sram_q[$];
   int          last_due = 0;
   int          lat_next = -1;
   bit          data_next_en = 0;
   logic [31:0] data_next;
   logic        req_force = 1'b0;
   instr_t      cur;
   logic [31:0] exp_q[$];

   // model of the instruction held in MEM
   bit          m_valid = 0;
   instr_t      m_ins;
   bit          m_got = 0;
   logic [31:0] m_data;
   // per-cycle model predictions
   bit          e_ready, e_allowin, e_to_wb, e_pending, resp_live;
   logic [31:0] e_result;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, got no event, expected one (cycle %0d)", name, cyc);
   endtask

   // Load extraction written from the instruction semantics.
   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] op,
                                              input logic [1:0] lo);
      longint unsigned v;
      v = w;
      for (int i = 0; i < int'(lo); i++) v = v / 256;
      if (op[2]) begin
         v = v % 256;
         if (!op[0] && v >= 128) v = v + 64'hFFFF_FF00;
      end else if (op[1]) begin
         v = v % 65536;
         if (!op[0] && v >= 32768) v = v + 64'hFFFF_0000;
      end else begin
         v = w;
      end
      return v[31:0];
   endfunction

   function automatic int dead_count();
      int n = 0;
      foreach (sram_q[i]) if (sram_q[i].dead) n++;
      return n;
   endfunction

   function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] res,
                                 input logic rf_we, input logic ld, input logic [2:0] op,
                                 input logic req, input logic ex);
      instr_t t;
      t.pc = pc; t.result = res; t.rf_we = rf_we; t.waddr = 5'd7;
      t.res_from_mem = ld; t.ld_op = op; t.addr_lo = res[1:0];
      t.mem_req = req; t.excep = ex; t.ertn = 1'b0;
      return t;
   endfunction

   function automatic instr_t gen_instr(input int n);
      instr_t t;
      int k;
      t.pc = 32'h1C00_0000 + 32'(n * 4);
      t.result = $urandom;
      t.rf_we = 1'($urandom_range(0, 1));
      t.waddr = 5'($urandom_range(0, 31));
      t.res_from_mem = 0; t.ld_op = 0; t.addr_lo = 0;
      t.mem_req = 0; t.excep = 0; t.ertn = 0;
      k = $urandom_range(0, 9);
      if (k <= 3) begin
         t.res_from_mem = 1; t.mem_req = 1; t.rf_we = 1;
         case ($urandom_range(0, 4))
            0: begin t.ld_op = 3'b000; t.addr_lo = 2'd0; end
            1: begin t.ld_op = 3'b100; t.addr_lo = 2'($urandom_range(0, 3)); end
            2: begin t.ld_op = 3'b101; t.addr_lo = 2'($urandom_range(0, 3)); end
            3: begin t.ld_op = 3'b010; t.addr_lo = 2'($urandom_range(0, 1) * 2); end
            default: begin t.ld_op = 3'b011; t.addr_lo = 2'($urandom_range(0, 1) * 2); end
         endcase
         t.result[1:0] = t.addr_lo;
      end else if (k == 4) begin
         t.mem_req = 1; t.rf_we = 0;
      end else if (k == 8) begin
         t.excep = 1; t.res_from_mem = 1'($urandom_range(0, 1));
      end else if (k == 9) begin
         t.ertn = 1; t.rf_we = 0;
      end
      return t;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_ex(input logic v, input instr_t t);
      cur             = t;
      ex_to_mem_valid = v;
      ex_pc           = t.pc;
      ex_result       = t.result;
      ex_rf_we        = t.rf_we;
      ex_rf_waddr     = t.waddr;
      ex_res_from_mem = t.res_from_mem;
      ex_ld_op        = t.ld_op;
      ex_addr_lo      = t.addr_lo;
      ex_mem_req      = t.mem_req;
      ex_excep_en     = t.excep;
      ex_ertn         = t.ertn;
   endtask

   // Per-cycle check of every DUT output against the model.
   task automatic compare();
      if (!resetn) return;
      chk("mem_allowin", mem_allowin, e_allowin);
      chk("mem_to_wb_valid", mem_to_wb_valid, e_to_wb);
      chk("load_pending", mem_to_id_bus[38], e_pending);
      chk("id_rf_we", mem_to_id_bus[37], m_valid & m_ins.rf_we);
      chk("mem_rf_we", mem_rf_we, m_valid & m_ins.rf_we);
      chk("mem_excep_en", mem_excep_en, m_valid & m_ins.excep);
      chk("mem_to_ex_bus", mem_to_ex_bus, {m_valid & m_ins.excep, m_valid & m_ins.ertn});
      chk("outst_cnt", dbg_outst_cnt, sram_q.size());
      chk("outst_bound", dbg_outst_cnt <= MAX_OUTST, 1);
      chk("discard_cnt", dbg_discard_cnt, dead_count());
      chk("rbuf_valid", dbg_rbuf_valid, m_valid & m_got);
      if (m_valid) begin
         chk("mem_pc", mem_pc, m_ins.pc);
         chk("mem_rf_waddr", mem_rf_waddr, m_ins.waddr);
         chk("id_waddr", mem_to_id_bus[36:32], m_ins.waddr);
         if (e_ready) begin
            chk("mem_final_result", mem_final_result, e_result);
            chk("id_result", mem_to_id_bus[31:0], e_result);
         end
      end
      if (mem_to_wb_valid && wb_allowin)
         chk("retire_pc", mem_pc, (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx);
   endtask

   // Drive the SRAM, let combinational outputs settle, predict and compare.
   task automatic step_pre();
      logic [31:0] word;
      bit dead_now;
      if (resetn && sram_q.size() > 0 && sram_q[0].due <= cyc) begin
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = sram_q[0].data;
      end else begin
         data_sram_data_ok = 1'b0;
         data_sram_rdata   = $urandom;
      end
      #1;
      req_accepted = resetn & (req_force | (ex_to_mem_valid & ex_mem_req & mem_allowin));
      #1;
      dead_now  = data_sram_data_ok && sram_q.size() > 0 && sram_q[0].dead;
      resp_live = m_valid && m_ins.mem_req && !m_got && data_sram_data_ok && !dead_now;
      e_ready   = !m_ins.mem_req || m_got || resp_live;
      e_allowin = !m_valid || (e_ready && wb_allowin);
      e_to_wb   = m_valid && e_ready && !flush;
      e_pending = m_valid && m_ins.res_from_mem && !e_ready;
      word      = m_got ? m_data : data_sram_rdata;
      e_result  = (m_ins.res_from_mem && !m_ins.excep) ?
                  model_load(word, m_ins.ld_op, m_ins.addr_lo) : m_ins.result;
      compare();
   endtask

   // Clock edge: advance the model, then return at the next falling edge.
   task automatic step_post();
      resp_t r;
      int lat;
      @(posedge clk);
      if (!resetn) begin
         sram_q.delete();
         exp_q.delete();
         last_due = 0;
         m_valid  = 0;
         m_got    = 0;
      end else begin
         if (data_sram_data_ok && sram_q.size() > 0) void'(sram_q.pop_front());
         if (req_accepted) begin
            lat    = (lat_next > 0) ? lat_next : $urandom_range(1, 4);
            r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            r.data = data_next_en ? data_next : $urandom;
            r.dead = 0;
            last_due = r.due;
            sram_q.push_back(r);
            lat_next = -1;
            data_next_en = 0;
         end
         if (flush) foreach (sram_q[i]) sram_q[i].dead = 1;
         if (e_to_wb && wb_allowin && exp_q.size() > 0) void'(exp_q.pop_front());
         if (flush) begin
            m_valid = 0;
            exp_q.delete();
         end else if (e_allowin) begin
            m_valid = ex_to_mem_valid;
            m_ins   = cur;
            m_got   = 0;
            if (ex_to_mem_valid) exp_q.push_back(cur.pc);
         end else if (resp_live) begin
            m_got  = 1;
            m_data = data_sram_rdata;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   // One instruction through an idle stage with WB open; literal checks at WB.
   task automatic run_one(input instr_t t, input int lat, input logic [31:0] data,
                          input logic [31:0] exp_res, input logic exp_we,
                          input logic [1:0] exp_bus, input string name);
      bit taken = 0;
      bit seen  = 0;
      wb_allowin = 1'b1; flush = 1'b0;
      lat_next = lat; data_next = data; data_next_en = 1;
      for (int i = 0; i < 12 && !taken; i++) begin
         drive_ex(1'b1, t);
         step_pre();
         taken = mem_allowin;
         step_post();
      end
      drive_ex(1'b0, t);
      for (int i = 0; i < 12 && !seen; i++) begin
         step_pre();
         if (mem_to_wb_valid) begin
            seen = 1;
            chk({name, "_result"}, mem_final_result, exp_res);
            chk({name, "_rf_we"}, mem_rf_we, exp_we);
            chk({name, "_ex_bus"}, mem_to_ex_bus, exp_bus);
         end
         step_post();
      end
      if (!seen) fail_timeout(name);
      lat_next = -1; data_next_en = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      instr_t t;
      instr_t offer;
      bit have_offer = 0;
      bit taken;
      int n = 0;
      bit done;

      resetn = 1'b0; flush = 1'b0; wb_allowin = 1'b1; req_accepted = 1'b0;
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
      t = mk(32'h0, 32'h0, 0, 0, 3'b000, 0, 0);
      drive_ex(1'b0, t);
      step_pre(); step_post();
      step_pre(); step_post();
      resetn = 1'b1;

      // reset state
      step_pre();
      chk("rst_allowin", mem_allowin, 1);
      chk("rst_to_wb", mem_to_wb_valid, 0);
      chk("rst_result", mem_final_result, 32'h0);
      chk("rst_id_bus", mem_to_id_bus[31:0], 32'h0);
      chk("rst_id_bus_hi", mem_to_id_bus[38:32], 7'h0);
      chk("rst_pc", mem_pc, 32'h0);
      chk("rst_ex_bus", mem_to_ex_bus, 2'b00);
      step_post();

      // ld.w at 0x1C000004 with one wait cycle
      t = mk(32'h1C00_0004, 32'h0000_1000, 1, 1, 3'b000, 1, 0);
      lat_next = 2; data_next = 32'h89AB_CDEF; data_next_en = 1;
      drive_ex(1'b1, t);
      step_pre(); chk("ldw_allowin", mem_allowin, 1); step_post();
      drive_ex(1'b0, t);
      step_pre();
      chk("ldw_wait_pending", mem_to_id_bus[38], 1);
      chk("ldw_wait_to_wb", mem_to_wb_valid, 0);
      step_post();
      step_pre();
      chk("ldw_to_wb", mem_to_wb_valid, 1);
      chk("ldw_result", mem_final_result, 32'h89AB_CDEF);
      chk("ldw_pending_done", mem_to_id_bus[38], 0);
      chk("ldw_pc", mem_pc, 32'h1C00_0004);
      step_post();
      step_pre(); chk("ldw_to_wb_once", mem_to_wb_valid, 0); step_post();

      // byte/half extraction
      run_one(mk(32'h1C00_0010, 32'h0000_2002, 1, 1, 3'b100, 1, 0), 1, 32'h00F6_0000,
              32'hFFFF_FFF6, 1, 2'b00, "ld_b");
      run_one(mk(32'h1C00_0014, 32'h0000_2002, 1, 1, 3'b101, 1, 0), 2, 32'h00F6_0000,
              32'h0000_00F6, 1, 2'b00, "ld_bu");
      run_one(mk(32'h1C00_0018, 32'h0000_2002, 1, 1, 3'b010, 1, 0), 1, 32'h8001_0000,
              32'hFFFF_8001, 1, 2'b00, "ld_h");

      // response while WB is stalled: held in the buffer across garbage rdata
      t = mk(32'h1C00_0020, 32'h0000_3000, 1, 1, 3'b000, 1, 0);
      lat_next = 1; data_next = 32'h1357_2468; data_next_en = 1;
      drive_ex(1'b1, t); wb_allowin = 1'b1;
      step_pre(); step_post();
      drive_ex(1'b0, t); wb_allowin = 1'b0;
      step_pre(); chk("rbuf_first_to_wb", mem_to_wb_valid, 1); step_post();
      for (int i = 0; i < 2; i++) begin
         step_pre();
         chk("rbuf_held_valid", dbg_rbuf_valid, 1);
         chk("rbuf_held_result", mem_final_result, 32'h1357_2468);
         chk("rbuf_held_allowin", mem_allowin, 0);
         step_post();
      end
      wb_allowin = 1'b1;
      step_pre();
      chk("rbuf_release_to_wb", mem_to_wb_valid, 1);
      chk("rbuf_release_result", mem_final_result, 32'h1357_2468);
      step_post();
      step_pre(); chk("rbuf_cleared", dbg_rbuf_valid, 0); step_post();

      // flush with one load waiting and another request accepted the same cycle
      t = mk(32'h1C00_0030, 32'h0000_4000, 1, 1, 3'b000, 1, 0);
      lat_next = 5;
      drive_ex(1'b1, t);
      step_pre(); step_post();
      drive_ex(1'b0, t);
      step_pre(); chk("flush_pre_pending", mem_to_id_bus[38], 1); step_post();
      flush = 1'b1; req_force = 1'b1; lat_next = 2;
      step_pre(); chk("flush_to_wb", mem_to_wb_valid, 0); step_post();
      flush = 1'b0; req_force = 1'b0;
      step_pre();
      chk("flush_discard_2", dbg_discard_cnt, 2);
      chk("flush_outst_2", dbg_outst_cnt, 2);
      step_post();
      done = 0;
      for (int i = 0; i < 15 && !done; i++) begin
         step_pre();
         done = (sram_q.size() == 0);
         step_post();
      end
      if (!done) fail_timeout("flush_drain");
      step_pre(); chk("flush_drained_discard", dbg_discard_cnt, 0); step_post();
      run_one(mk(32'h1C00_0040, 32'h0000_5000, 1, 1, 3'b000, 1, 0), 1, 32'h0BAD_F00D,
              32'h0BAD_F00D, 1, 2'b00, "post_flush_ldw");

      // store and misaligned (ALE) load
      run_one(mk(32'h1C00_0050, 32'h0000_6004, 0, 0, 3'b000, 1, 0), 2, 32'hDEAD_BEEF,
              32'h0000_6004, 0, 2'b00, "store");
      run_one(mk(32'h1C00_0054, 32'h1C00_00A3, 1, 1, 3'b000, 0, 1), 1, 32'h0,
              32'h1C00_00A3, 1, 2'b10, "ale");

      // reset during a wait
      t = mk(32'h1C00_0060, 32'h0000_7000, 1, 1, 3'b000, 1, 0);
      lat_next = 4;
      drive_ex(1'b1, t);
      step_pre(); step_post();
      drive_ex(1'b0, t);
      step_pre(); chk("rstmid_outst_1", dbg_outst_cnt, 1); step_post();
      resetn = 1'b0;
      step_pre(); step_post();
      resetn = 1'b1;
      step_pre();
      chk("rstmid_allowin", mem_allowin, 1);
      chk("rstmid_to_wb", mem_to_wb_valid, 0);
      chk("rstmid_outst", dbg_outst_cnt, 0);
      chk("rstmid_discard", dbg_discard_cnt, 0);
      chk("rstmid_id_bus", mem_to_id_bus[38:32], 7'h0);
      step_post();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         resetn     = 1'b1;
         flush      = ($urandom_range(0, 99) < 4);
         wb_allowin = ($urandom_range(0, 99) < 70);
         if (!have_offer && $urandom_range(0, 99) < 65) begin
            offer = gen_instr(n);
            n++;
            have_offer = 1;
         end
         drive_ex(have_offer && !(offer.mem_req && sram_q.size() >= MAX_OUTST), offer);
         step_pre();
         taken = ex_to_mem_valid & mem_allowin;
         step_post();
         if (taken || flush) have_offer = 0;
      end

      // drain
      flush = 1'b0; wb_allowin = 1'b1;
      drive_ex(1'b0, offer);
      for (int i = 0; i < 20; i++) begin
         step_pre(); step_post();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the LoongArch pipeline, between EX and WB.
- Latches EX results and waits for the data-SRAM response (data_ok) of loads and stores issued by EX.
- Aligns and extends load data, then forwards the result to WB and bypass/hazard info to ID.
- Tracks outstanding SRAM transactions so that responses belonging to flushed instructions are discarded.

Parameters:
- MAX_OUTST, 2, maximum outstanding data-SRAM transactions tracked; counter width is clog2(MAX_OUTST+1).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- flush  in  1  exception/ertn flush from WB.
- ex_to_mem_valid  in  1  EX has a valid instruction ready.
- mem_allowin  out  1  MEM can accept from EX.
- ex_pc  in  32  instruction PC.
- ex_result  in  32  ALU/counter result; this is the load/store virtual address for memory ops.
- ex_rf_we  in  1  register write enable.
- ex_rf_waddr  in  5  destination register.
- ex_res_from_mem  in  1  instruction is a load.
- ex_ld_op  in  3  {b,h,u}; b=0 and h=0 means word.
- ex_addr_lo  in  2  physical address bits [1:0].
- ex_mem_req  in  1  EX issued an SRAM request for this instruction.
- ex_excep_en  in  1  instruction carries an exception.
- ex_ertn  in  1  instruction is ertn.
- req_accepted  in  1  data_sram_req & data_sram_addr_ok, seen this cycle.
- data_sram_data_ok  in  1  response valid.
- data_sram_rdata  in  32  response data.
- wb_allowin  in  1  WB can accept.
- mem_to_wb_valid  out  1  valid to WB.
- mem_pc  out  32  PC to WB.
- mem_final_result  out  32  writeback value.
- mem_rf_we  out  1  write enable to WB; gated by mem_valid.
- mem_rf_waddr  out  5  destination to WB.
- mem_excep_en  out  1  exception to WB; gated by mem_valid.
- mem_to_ex_bus  out  2  {mem_excep_en&mem_valid, mem_ertn&mem_valid}.
- mem_to_id_bus  out  39  {load_pending, mem_rf_we&mem_valid, mem_rf_waddr, mem_final_result}.

Behaviour:
- Reset:
  - mem_valid=0, all latched fields=0.
  - outst_cnt=0, discard_cnt=0, rbuf_valid=0, rbuf=0.
  - All outputs 0 except mem_allowin=1.
- Handshake:
  - ready_go = ~mem_mem_req | data_ok_eff | rbuf_valid.
  - data_ok_eff = data_sram_data_ok & (discard_cnt==0).
  - mem_allowin = ~mem_valid | (ready_go & wb_allowin).
  - mem_to_wb_valid = mem_valid & ready_go & ~flush.
- Latching:
  - mem_valid: flush → 0; else if mem_allowin → ex_to_mem_valid.
  - Fields load on ex_to_mem_valid & mem_allowin.
- Response buffer:
  - Capture rbuf on data_ok_eff & mem_valid & ~wb_allowin; set rbuf_valid.
  - Clear rbuf_valid when the instruction moves to WB (mem_valid & ready_go & wb_allowin) or on flush.
- Outstanding counter:
  - outst_cnt += req_accepted, −= data_sram_data_ok, in the same cycle (net 0 if both occur).
  - Must never exceed MAX_OUTST or go below 0; violation is a bench assertion failure.
- Flush:
  - discard_cnt ← outst_cnt + req_accepted − data_sram_data_ok, which is the number of responses still owed after this cycle.
  - Afterwards, each data_sram_data_ok with discard_cnt>0 decrements discard_cnt and is ignored: no capture, no ready_go.
- Load data:
  - shifted = rdata_src >> (8*addr_lo), where rdata_src = rbuf_valid ? rbuf : data_sram_rdata.
  - b: {24{~u & shifted[7]}, shifted[7:0]}.
  - h: {16{~u & shifted[15]}, shifted[15:0]}.
  - w: rdata_src.
- Result select:
  - mem_final_result = res_from_mem & ~excep_en ? load_data : mem_result.
  - A faulting load has mem_mem_req=0 and passes ex_result (badv) straight through.
- Hazard/bypass:
  - load_pending = mem_valid & res_from_mem & ~ready_go; ID stalls on it.
  - Once ready_go, the forwarded value is the load data.
- Simultaneous events:
  - flush and data_ok in the same cycle: response counted as consumed, not discarded, but the instruction is dropped.
  - New EX entry may be latched the same cycle the old one leaves.

Test Plan:
- ld.w at 0x1C000004, data_ok one cycle after latch, rdata=0x89ABCDEF, wb_allowin=1 → mem_final_result=0x89ABCDEF, mem_to_wb_valid high one cycle, load_pending high during the wait cycle.
- ld.b addr_lo=2, rdata=0x00F60000 → 0xFFFFFFF6; ld.bu same → 0x000000F6; ld.h addr_lo=2, rdata=0x80010000 → 0xFFFF8001.
- Load data_ok arrives while wb_allowin=0 for 3 cycles, rdata then changes to garbage → rbuf holds the original data; WB receives it when wb_allowin=1, and rbuf_valid clears.
- Flush with one load waiting plus req_accepted in the same cycle → discard_cnt=2; the next two data_ok are ignored, then a fresh ld.w completes normally.
- Store (ex_mem_req=1, rf_we=0) with data_ok → passes with mem_rf_we=0; ALE instruction (excep_en=1, mem_req=0) → passes immediately with mem_final_result=badv and mem_to_ex_bus=2'b10.
- resetn low mid-wait (outst_cnt=1) → all counters 0, mem_valid=0 next cycle, mem_allowin=1.
